text_fetch_sched: RTL
=====================

# text_fetch_sched

Scheduler that shares one synchronous text-row ROM among three on-screen text windows. During each line's horizontal blanking it fetches the next scanline's pixel row for every window that covers that scanline, in a fixed order. It double-buffers the rows so the pixel-compositing logic sees stable row data for the whole active line. It sits between the VGA sync counters (HCount/VCount) and the text-object overlay logic.

## Interface
Parameters:
- ROW_W, 210: ROM data width (pixels per text row).
- ADDR_W, 8: ROM address width.
- HFETCH_START, 640: HCount value that starts a fetch burst.
- HTOTAL, 800: horizontal count period.
- VTOTAL, 525: vertical count period.

Ports:
- clk, input, 1: pixel clock. Single clock domain.
- reset_n, input, 1: synchronous, active-low reset.
- HCount, input, 10: current horizontal count.
- VCount, input, 10: current vertical count.
- win_en, input, 3: per-window enable.
- win_y_top, input, 3x10 (packed 30): per-window top scanline.
- win_height, input, 3x8 (packed 24): per-window height in rows.
- win_base, input, 3xADDR_W (packed 24): per-window ROM base address.
- rom_en, output, 1: ROM read strobe.
- rom_addr, output, ADDR_W: ROM read address.
- rom_data, input, ROW_W: ROM read data, valid one cycle after rom_en.
- row0, row1, row2, output, ROW_W each: committed row per window.
- row_valid, output, 3: the committed row for window i is live on this line.
- busy, output, 1: a fetch burst is in progress.
- overrun, output, 1: one-cycle pulse when a commit is skipped.

## Operation
- States: IDLE, ISSUE(i), CAPTURE(i) for i = 0..2, READY.
- IDLE to ISSUE(0): on the cycle HCount == HFETCH_START is sampled. That same cycle latches:
  - target line L = VCount + 1, wrapping to 0 when VCount == VTOTAL-1;
  - all window config inputs.
- Config changes after the latch cycle have no effect until the next burst.
- Hit test for window i: win_en[i] && L >= y_top && L <= y_top + height - 1. Use 11-bit arithmetic with no wrap. height == 0 never hits.
- ISSUE(i):
  - on a hit: rom_en = 1, rom_addr = base + (L - y_top), truncated to ADDR_W (wrap in ROM space);
  - on a miss: rom_en = 0 and rom_addr holds its value.
  - Next state is CAPTURE(i).
- CAPTURE(i):
  - stage[i] = rom_data and stage_valid[i] = 1 on a hit;
  - stage[i] = 0 and stage_valid[i] = 0 on a miss.
  - Next state is ISSUE(i+1), or READY after i = 2.
- Every slot costs exactly 2 cycles whether it hits or misses, so burst length is fixed at 6 cycles.
- READY to IDLE: on the cycle HCount == HTOTAL-1 is sampled. The commit copies stage[0..2] to row0..row2 and stage_valid to row_valid, all in the same edge.
- HCount == HTOTAL-1 sampled outside READY (burst still busy, or no burst this line):
  - no commit; rows and row_valid hold;
  - overrun pulses for one cycle;
  - a running burst continues, then returns to IDLE with its data discarded (no commit).
- An HCount == HFETCH_START sample while not in IDLE is ignored.
- ROM reads are issued only in ISSUE states, with at most one read per cycle.

## Timing
- Reset (reset_n low at an edge): state IDLE; rom_en 0; rom_addr 0; row0..row2 0; row_valid 0; stage cleared; busy 0; overrun 0. Reset mid-burst aborts with no commit.
- Let T be the edge sampling HCount == HFETCH_START.
- ISSUE(0/1/2) outputs are registered and appear after edges T, T+2, T+4. CAPTURE samples rom_data at edges T+2, T+4, T+6.
- busy is high for the cycles after edges T through T+5 and drops after edge T+6.
- Commit: the rows change after the edge sampling HCount == HTOTAL-1 and are stable for the whole of the next line, including active video.
- Latency from fetch start to data visible = (HTOTAL-1 - HFETCH_START) + 1 cycles.
- L wrap example: VCount = 524 at T gives L = 0.

## Test plan
- Single window: win_en = 001, y_top = 100, height = 25, base = 0x10. At VCount = 99, HCount = 640:
  - expect rom_en at T+1 with addr 0x10, and at T+3 and T+5 rom_en = 0;
  - after HCount = 799: row0 = ROM[0x10] and row_valid = 001.
- Edges of window 0 (same config as above):
  - VCount = 123 → addr 0x28 and row_valid[0] = 1;
  - VCount = 124 → row_valid[0] = 0 and row0 = 0;
  - VCount = 98 → miss.
- Three overlapping windows: win_en = 111, y_top = 10, 10, 10, height = 5, bases 0x00, 0x40, 0x80. At VCount = 11, expect addrs 0x02, 0x42, 0x82 at T+1, T+3, T+5, and all three rows committed together.
- Vertical wrap and height 0:
  - y_top = 0, height = 1, VCount = 524 → hit, addr = base;
  - height = 0 → row_valid stays 0 for all lines.
- Overrun: HFETCH_START = 796, HTOTAL = 800:
  - burst still busy at HCount = 799 → overrun pulses 1 cycle, rows unchanged from the prior line;
  - the following line with the default parameter commits normally.
- Reset mid-burst: drop reset_n at T+3 → next cycle rom_en = 0, busy = 0, row_valid = 000, and no commit at HCount = 799.

Source files
------------

// File: rtl/text_fetch_sched.sv
// Shares one text-row ROM among three windows: fetches next-line rows during
// horizontal blanking into a stage buffer and commits them at end of line.
module text_fetch_sched #(
   parameter int ROW_W        = 210,
   parameter int ADDR_W       = 8,
   parameter int HFETCH_START = 640,
   parameter int HTOTAL       = 800,
   parameter int VTOTAL       = 525
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [9:0]            HCount,
   input  logic [9:0]            VCount,
   input  logic [2:0]            win_en,
   input  logic [29:0]           win_y_top,
   input  logic [23:0]           win_height,
   input  logic [3*ADDR_W-1:0]   win_base,
   output logic                  rom_en,
   output logic [ADDR_W-1:0]     rom_addr,
   input  logic [ROW_W-1:0]      rom_data,
   output logic [ROW_W-1:0]      row0,
   output logic [ROW_W-1:0]      row1,
   output logic [ROW_W-1:0]      row2,
   output logic [2:0]            row_valid,
   output logic                  busy,
   output logic                  overrun
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISS0  = 3'd1;
   localparam logic [2:0] S_CAP0  = 3'd2;
   localparam logic [2:0] S_ISS1  = 3'd3;
   localparam logic [2:0] S_CAP1  = 3'd4;
   localparam logic [2:0] S_ISS2  = 3'd5;
   localparam logic [2:0] S_CAP2  = 3'd6;
   localparam logic [2:0] S_READY = 3'd7;

   logic [2:0]                  state_q, state_d;
   logic [2:0]                  hit_q, hit_d;
   logic [2:0][ADDR_W-1:0]      addr_q, addr_d;
   logic [2:0][ROW_W-1:0]       stage_q, stage_d;
   logic [2:0]                  stage_valid_q, stage_valid_d;
   logic [2:0][ROW_W-1:0]       row_q, row_d;
   logic [2:0]                  row_valid_q, row_valid_d;
   logic                        rom_en_q, rom_en_d;
   logic [ADDR_W-1:0]           rom_addr_q, rom_addr_d;
   logic                        discard_q, discard_d;
   logic                        overrun_q, overrun_d;

   logic [10:0]                 line_no, y_i, end_i, off_i;
   logic [2:0]                  cur_hit;
   logic [2:0][ADDR_W-1:0]      cur_addr;
   logic                        fetch_start, line_end, in_burst;

   // Per-window hit test and address are resolved once at fetch start and
   // kept, so config changes mid-burst cannot disturb the slots.
   always_comb begin
      line_no  = (VCount == 10'(VTOTAL-1)) ? '0 : 11'(VCount) + 11'd1;
      cur_hit  = '0;
      cur_addr = '0;
      y_i      = '0;
      end_i    = '0;
      off_i    = '0;
      for (int unsigned i = 0; i < 3; i++) begin
         y_i         = 11'(win_y_top[i*10 +: 10]);
         end_i       = y_i + 11'(win_height[i*8 +: 8]);
         off_i       = line_no - y_i;
         cur_hit[i]  = win_en[i] && (line_no >= y_i) && (line_no < end_i);
         cur_addr[i] = win_base[i*ADDR_W +: ADDR_W] + ADDR_W'(off_i);
      end
   end

   assign fetch_start = (state_q == S_IDLE) && (HCount == 10'(HFETCH_START));
   assign line_end    = (HCount == 10'(HTOTAL-1));
   assign in_burst    = (state_q != S_IDLE) && (state_q != S_READY);

   always_comb begin
      state_d       = state_q;
      hit_d         = hit_q;
      addr_d        = addr_q;
      stage_d       = stage_q;
      stage_valid_d = stage_valid_q;
      row_d         = row_q;
      row_valid_d   = row_valid_q;
      rom_en_d      = 1'b0;
      rom_addr_d    = rom_addr_q;
      discard_d     = discard_q;
      overrun_d     = line_end && (state_q != S_READY);
      if (line_end && in_burst) discard_d = 1'b1;
      case (state_q)
         S_IDLE: if (fetch_start) begin
            state_d   = S_ISS0;
            hit_d     = cur_hit;
            addr_d    = cur_addr;
            discard_d = 1'b0;
            rom_en_d  = cur_hit[0];
            if (cur_hit[0]) rom_addr_d = cur_addr[0];
         end
         S_ISS0, S_ISS1, S_ISS2: state_d = state_q + 3'd1;
         S_CAP0: begin
            stage_d[0]       = hit_q[0] ? rom_data : '0;
            stage_valid_d[0] = hit_q[0];
            state_d          = S_ISS1;
            rom_en_d         = hit_q[1];
            if (hit_q[1]) rom_addr_d = addr_q[1];
         end
         S_CAP1: begin
            stage_d[1]       = hit_q[1] ? rom_data : '0;
            stage_valid_d[1] = hit_q[1];
            state_d          = S_ISS2;
            rom_en_d         = hit_q[2];
            if (hit_q[2]) rom_addr_d = addr_q[2];
         end
         S_CAP2: begin
            stage_d[2]       = hit_q[2] ? rom_data : '0;
            stage_valid_d[2] = hit_q[2];
            // A burst overtaken by end of line drops straight back to idle.
            state_d          = (discard_q || line_end) ? S_IDLE : S_READY;
         end
         default: if (line_end) begin
            row_d       = stage_q;
            row_valid_d = stage_valid_q;
            state_d     = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         hit_q         <= '0;
         addr_q        <= '0;
         stage_q       <= '0;
         stage_valid_q <= '0;
         row_q         <= '0;
         row_valid_q   <= '0;
         rom_en_q      <= 1'b0;
         rom_addr_q    <= '0;
         discard_q     <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         hit_q         <= hit_d;
         addr_q        <= addr_d;
         stage_q       <= stage_d;
         stage_valid_q <= stage_valid_d;
         row_q         <= row_d;
         row_valid_q   <= row_valid_d;
         rom_en_q      <= rom_en_d;
         rom_addr_q    <= rom_addr_d;
         discard_q     <= discard_d;
         overrun_q     <= overrun_d;
      end
   end

   assign rom_en    = rom_en_q;
   assign rom_addr  = rom_addr_q;
   assign row0      = row_q[0];
   assign row1      = row_q[1];
   assign row2      = row_q[2];
   assign row_valid = row_valid_q;
   assign busy      = in_burst;
   assign overrun   = overrun_q;

endmodule
